// File: rtl/adj_pixel_fetcher.sv
// Radius-3 neighbour fetcher: turns (ref_addr, adj_num) requests into frame-buffer reads
// and publishes the eight gathered neighbours with a validity mask on request.
module adj_pixel_fetcher #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 135,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [14:0]        ref_addr,
  input  logic [2:0]         adj_num,
  input  logic               mat_readen,
  output logic               mem_rden,
  output logic [14:0]        mem_addr,
  input  logic [PIX_W-1:0]   mem_data,
  output logic [8*PIX_W-1:0] pix_vec,
  output logic [7:0]         pix_mask,
  output logic               vec_valid,
  output logic               busy,
  output logic               err_oob_ref
);

  // state | meaning
  // IDLE  | collecting neighbours, waiting for mat_readen
  // DRAIN | waiting for this round's in-flight fetches to land
  // PUB   | vec_valid high; mask cleared on exit
  typedef enum logic [1:0] {IDLE, DRAIN, PUB} state_t;

  localparam logic [14:0]        NPIX = 15'(IMG_W * IMG_H);
  localparam logic [14:0]        W15  = 15'(IMG_W);
  localparam logic signed [15:0] W_S  = 16'(IMG_W);
  localparam logic signed [15:0] H_S  = 16'(IMG_H);

  state_t state_q, state_d;

  logic [14:0]        x_u, y_u, lin;
  logic signed [15:0] dx, dy, nx, ny;
  logic               ref_ok, inb;

  logic               s1_valid, s1_cur;
  logic [2:0]         s1_adj;
  logic               s2_valid, s2_inb;
  logic [2:0]         s2_adj;

  assign x_u    = ref_addr % W15;
  assign y_u    = ref_addr / W15;
  assign ref_ok = ref_addr < NPIX;

  always_comb begin
    dx = 16'sd0;
    dy = 16'sd0;
    case (adj_num)
      3'd0: begin dx =  16'sd0; dy = -16'sd3; end
      3'd1: begin dx =  16'sd2; dy = -16'sd2; end
      3'd2: begin dx =  16'sd3; dy =  16'sd0; end
      3'd3: begin dx =  16'sd2; dy =  16'sd2; end
      3'd4: begin dx =  16'sd0; dy =  16'sd3; end
      3'd5: begin dx = -16'sd2; dy =  16'sd2; end
      3'd6: begin dx = -16'sd3; dy =  16'sd0; end
      3'd7: begin dx = -16'sd2; dy = -16'sd2; end
      default: begin dx = 16'sd0; dy = 16'sd0; end
    endcase
  end

  assign nx  = $signed({1'b0, x_u}) + dx;
  assign ny  = $signed({1'b0, y_u}) + dy;
  assign inb = ref_ok && (nx >= 16'sd0) && (nx < W_S) && (ny >= 16'sd0) && (ny < H_S);
  assign lin = 15'(ny * W_S + nx);

  // s1_cur marks requests that belong to the round being published;
  // anything accepted during DRAIN/PUB goes to the next round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_cur      <= 1'b0;
      s1_adj      <= 3'd0;
      mem_rden    <= 1'b0;
      mem_addr    <= 15'd0;
      err_oob_ref <= 1'b0;
      s2_valid    <= 1'b0;
      s2_inb      <= 1'b0;
      s2_adj      <= 3'd0;
    end else begin
      s1_valid <= req_valid;
      s1_cur   <= req_valid && (state_q == IDLE);
      s1_adj   <= adj_num;
      mem_rden <= req_valid && inb;
      mem_addr <= (req_valid && inb) ? lin : 15'd0;
      if (req_valid && !ref_ok)
        err_oob_ref <= 1'b1;
      s2_valid <= s1_valid;
      s2_inb   <= mem_rden;
      s2_adj   <= s1_adj;
    end
  end

  // A landing write must survive the mask clear on PUB exit, so it comes last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_vec  <= '0;
      pix_mask <= 8'd0;
    end else begin
      if (state_q == PUB)
        pix_mask <= 8'd0;
      if (s2_valid) begin
        pix_vec[s2_adj*PIX_W +: PIX_W] <= s2_inb ? mem_data : '0;
        pix_mask[s2_adj]               <= s2_inb;
      end
    end
  end

  assign busy = s1_valid | s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DRAIN may leave while the last current fetch sits in S2: it lands on the same edge.
  always_comb begin
    state_d   = state_q;
    vec_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (mat_readen)
          state_d = (!busy && !req_valid) ? PUB : DRAIN;
      end
      DRAIN: begin
        if (!(s1_valid && s1_cur))
          state_d = PUB;
      end
      PUB: begin
        vec_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adj_pixel_fetcher.sv
// Directed bench for adj_pixel_fetcher; the memory model returns the low address byte
// one cycle after each read strobe, and 8'hEE when no read was issued.
module tb_adj_pixel_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [14:0] ref_addr;
  logic [2:0]  adj_num;
  logic        mat_readen;
  logic        mem_rden;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic [63:0] pix_vec;
  logic [7:0]  pix_mask;
  logic        vec_valid;
  logic        busy;
  logic        err_oob_ref;

  int n_chk  = 0;
  int n_fail = 0;

  adj_pixel_fetcher #(.IMG_W(160), .IMG_H(135), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .ref_addr(ref_addr),
    .adj_num(adj_num), .mat_readen(mat_readen), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_vec(pix_vec),
    .pix_mask(pix_mask), .vec_valid(vec_valid), .busy(busy),
    .err_oob_ref(err_oob_ref)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_rden ? mem_addr[7:0] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [14:0] a, input logic [2:0] n);
    req_valid = 1'b1;
    ref_addr  = a;
    adj_num   = n;
  endtask

  int          exp1[8] = '{10, 172, 493, 812, 970, 808, 487, 168};
  int          exp2[8] = '{0, 0, 3, 322, 480, 0, 0, 0};
  logic [7:0]  rd2     = 8'b0001_1100;
  logic [14:0] ref4[9] = '{15'd8080, 15'd8080, 15'd8080, 15'd8080, 15'd8080,
                           15'd8080, 15'd8080, 15'd8080, 15'd490};
  logic [2:0]  adj4[9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
  int          exp4[9] = '{7600, 7762, 8083, 8402, 8560, 8398, 8077, 7758, 493};

  initial begin
    rst = 1'b1; req_valid = 1'b0; ref_addr = 15'd0; adj_num = 3'd0; mat_readen = 1'b0;
    #2;
    chk("rst_rden",  64'(mem_rden),    64'd0);
    chk("rst_addr",  64'(mem_addr),    64'd0);
    chk("rst_vec",   pix_vec,          64'd0);
    chk("rst_mask",  64'(pix_mask),    64'd0);
    chk("rst_vv",    64'(vec_valid),   64'd0);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_err",   64'(err_oob_ref), 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // interior round, publish requested three cycles after adj 7
    for (int i = 0; i < 8; i++) begin
      req(15'd490, 3'(i));
      step();
      chk("t1_rden", 64'(mem_rden), 64'd1);
      chk("t1_addr", 64'(mem_addr), 64'(exp1[i]));
    end
    req_valid = 1'b0;
    chk("t1_busy_s8", 64'(busy), 64'd1);
    step(); step();
    chk("t1_busy_s10", 64'(busy), 64'd0);
    chk("t1_vv_s10", 64'(vec_valid), 64'd0);
    mat_readen = 1'b1;
    step();
    mat_readen = 1'b0;
    chk("t1_vv_s11", 64'(vec_valid), 64'd1);
    chk("t1_mask", 64'(pix_mask), 64'hFF);
    chk("t1_vec", pix_vec, 64'hA8E728CA2CEDAC0A);
    step();
    chk("t1_vv_s12", 64'(vec_valid), 64'd0);
    chk("t1_mask_clr", 64'(pix_mask), 64'd0);
    chk("t1_vec_kept", pix_vec, 64'hA8E728CA2CEDAC0A);

    // corner round, publish requested one cycle after adj 7 (DRAIN path)
    for (int i = 0; i < 8; i++) begin
      req(15'd0, 3'(i));
      step();
      chk("t2_rden", 64'(mem_rden), 64'(rd2[i]));
      chk("t2_addr", 64'(mem_addr), 64'(exp2[i]));
    end
    req_valid = 1'b0;
    mat_readen = 1'b1;
    step();
    chk("t2_vv_drain", 64'(vec_valid), 64'd0);
    chk("t2_busy_drain", 64'(busy), 64'd1);
    step();
    mat_readen = 1'b0;
    chk("t2_vv_pub", 64'(vec_valid), 64'd1);
    chk("t2_mask", 64'(pix_mask), 64'h1C);
    chk("t2_vec", pix_vec, 64'h000000E042030000);
    step();
    chk("t2_vv_after", 64'(vec_valid), 64'd0);
    chk("t2_mask_clr", 64'(pix_mask), 64'd0);

    // out-of-range reference address
    req(15'd21600, 3'd2);
    step();
    req_valid = 1'b0;
    chk("t3_rden", 64'(mem_rden), 64'd0);
    chk("t3_err", 64'(err_oob_ref), 64'd1);
    step(); step();
    chk("t3_busy", 64'(busy), 64'd0);
    mat_readen = 1'b1;
    step();
    mat_readen = 1'b0;
    chk("t3_vv", 64'(vec_valid), 64'd1);
    chk("t3_mask", 64'(pix_mask), 64'd0);
    chk("t3_vec", pix_vec, 64'h000000E042000000);
    step();
    chk("t3_err_held", 64'(err_oob_ref), 64'd1);

    // reset mid-round after adj 3
    for (int i = 0; i < 4; i++) begin
      req(15'd490, 3'(i));
      step();
    end
    req_valid = 1'b0;
    chk("t4_err_pre", 64'(err_oob_ref), 64'd1);
    rst = 1'b1;
    #1;
    chk("t4_rden", 64'(mem_rden), 64'd0);
    chk("t4_addr", 64'(mem_addr), 64'd0);
    chk("t4_vec", pix_vec, 64'd0);
    chk("t4_mask", 64'(pix_mask), 64'd0);
    chk("t4_vv", 64'(vec_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_err", 64'(err_oob_ref), 64'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_quiet_vv", 64'(vec_valid), 64'd0);
      chk("t4_quiet_busy", 64'(busy), 64'd0);
    end

    // fresh round with a duplicate adj 2, publish in the same cycle as the last request,
    // and a next-round request issued during DRAIN
    for (int i = 0; i < 9; i++) begin
      req(ref4[i], adj4[i]);
      if (i == 8) mat_readen = 1'b1;
      step();
      chk("t5_rden", 64'(mem_rden), 64'd1);
      chk("t5_addr", 64'(mem_addr), 64'(exp4[i]));
    end
    mat_readen = 1'b0;
    req(15'd490, 3'd4);
    chk("t5_vv_l1", 64'(vec_valid), 64'd0);
    step();
    req_valid = 1'b0;
    chk("t5_vv_l2", 64'(vec_valid), 64'd0);
    chk("t5_next_addr", 64'(mem_addr), 64'd970);
    step();
    chk("t5_vv_l3", 64'(vec_valid), 64'd1);
    chk("t5_mask", 64'(pix_mask), 64'hFF);
    chk("t5_vec", pix_vec, 64'h4E8DCE70D2ED52B0);
    step();
    chk("t5_vv_l4", 64'(vec_valid), 64'd0);
    chk("t5_mask_next", 64'(pix_mask), 64'h10);
    chk("t5_vec_next", pix_vec, 64'h4E8DCECAD2ED52B0);
    chk("t5_busy_end", 64'(busy), 64'd0);
    chk("t5_err_end", 64'(err_oob_ref), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adj_pixel_fetcher.md
Name: adj_pixel_fetcher

Overview:
- Responder for the match counter's adjacency sequence: for each (ref_addr, adj_num) request it fetches the selected radius-3 neighbour pixel from image memory.
- Stores up to 8 neighbours in a register file.
- When the counter raises its read-enable, it publishes the 8 neighbours as one packed vector with a validity mask for the FAST9 comparator.
- Sits between the match counter and the frame-buffer read port.

Parameters:
- IMG_W, 160, image width in pixels
- IMG_H, 135, image height in pixels (IMG_W*IMG_H = 21600 pixel addresses, 0..21599)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  neighbour fetch request this cycle
- ref_addr  in  15  linear address of centre pixel (y*IMG_W + x)
- adj_num  in  3  neighbour index 0..7
- mat_readen  in  1  counter signals all 8 neighbours requested; publish vector
- mem_rden  out  1  frame-buffer read strobe
- mem_addr  out  15  frame-buffer read address
- mem_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rden
- pix_vec  out  8*PIX_W  neighbour k in bits [k*PIX_W +: PIX_W]
- pix_mask  out  8  bit k = neighbour k fetched in-bounds this round
- vec_valid  out  1  one-cycle pulse: pix_vec/pix_mask valid
- busy  out  1  a fetch is in flight
- err_oob_ref  out  1  sticky: request with ref_addr >= IMG_W*IMG_H

Behaviour:
- Reset (async): mem_rden=0, mem_addr=0, pix_vec=0, pix_mask=0, vec_valid=0, busy=0, err_oob_ref=0. All in-flight fetches are discarded. A pending publish is cancelled.
- Coordinates: x = ref_addr % IMG_W, y = ref_addr / IMG_W, using constant divide.
- Neighbour offsets (dx,dy) by adj_num:
  - 0 (0,-3), 1 (+2,-2), 2 (+3,0), 3 (+2,+2)
  - 4 (0,+3), 5 (-2,+2), 6 (-3,0), 7 (-2,-2)
- In-bounds test: 0 <= x+dx < IMG_W and 0 <= y+dy < IMG_H. Use signed arithmetic at least 9 bits wide.
- Pipeline, request at cycle T:
  - S1 (T+1): registered mem_rden = in-bounds, mem_addr = (y+dy)*IMG_W + (x+dx). If out of bounds, mem_addr=0 and mem_rden=0.
  - S2 (T+2): mem_data sampled. Entry adj_num <- mem_data and mask bit <- 1. If out of bounds, entry <- 0 and mask bit <- 0.
  - Entry is visible on pix_vec from T+3.
  - Throughput: one request per cycle, fully pipelined.
- busy = 1 while any of S1/S2 holds a valid request.
- Duplicate adj_num within a round: the later write wins, last in pipeline order.
- ref_addr >= 21600: request treated as out-of-bounds (entry 0, mask 0), and err_oob_ref is set. err_oob_ref clears only on reset.
- Publish FSM, states IDLE, DRAIN, PUB:
  - IDLE: mat_readen=1 with busy=0 and no request this cycle -> PUB. Otherwise, mat_readen=1 -> DRAIN.
  - DRAIN: wait until pipeline empty (max 2 cycles), then -> PUB. mat_readen re-asserted in DRAIN is ignored.
  - PUB: vec_valid=1 for exactly one cycle. pix_vec/pix_mask hold the snapshot this cycle. Next edge clears pix_mask to 0 (pix_vec retained) -> IDLE.
- Latency: mat_readen at T with the pipeline empty gives vec_valid at T+1.
- A req_valid arriving during DRAIN/PUB is accepted into the pipeline and belongs to the next round. Its write is not cleared by the PUB mask-clear: the write takes priority over the clear on the same edge.
- mat_readen during PUB starts a new publish after IDLE (re-evaluated next cycle).

Test Plan:
- Interior pixel ref_addr=3*160+10=490, adj 0..7 on consecutive cycles, memory returns data=addr[7:0], mat_readen 3 cycles after adj 7:
  - mem_addr sequence 10, 172, 493, 812, 970, 808, 487, 168.
  - vec_valid pulses once; pix_mask=8'hFF; pix_vec entries match the low address bytes.
- Corner ref_addr=0, adj 0..7:
  - mem_rden only for adj 2,3,4 (addresses 3, 322, 480).
  - pix_mask=8'b0001_1100; masked entries are 0.
- Counter timing (adj 0..7 at S0..S7, mat_readen at S10) -> vec_valid at S10+1 with all 8 entries captured, no DRAIN dwell.
- mat_readen one cycle after adj 7 -> FSM enters DRAIN; vec_valid 2 cycles later with entry 7 present.
- ref_addr=21600 request -> mem_rden=0, mask bit 0, err_oob_ref=1 held until rst.
- rst pulsed mid-round after adj 3 issued -> all outputs zero, no vec_valid; a subsequent full round publishes correct data with no stale entries.
